mp_add_sequencer: RTL
=====================

// Module: mp_add_sequencer
// PURPOSE
//  Multi-cycle sequencer for wide add/subtract. Streams OPERAND_WIDTH-bit operands through one
//  ADDER_WIDTH-bit carry-lookahead slice, one chunk per cycle, LSB chunk first. The carry is
//  registered between chunks. Sits between a valid/ready producer and consumer.
//  Trades latency for area against a full-width adder.
// PARAMETERS
//  ADDER_WIDTH    8   slice width in bits (slice: iA,iB,iC -> oSum,oC, purely combinational)
//  OPERAND_WIDTH  64  full operand width; must be an integer multiple of ADDER_WIDTH
//  NUM_CHUNKS     OPERAND_WIDTH/ADDER_WIDTH (localparam, >=1); chunk counter is $clog2(NUM_CHUNKS+1) bits
// PORTS
//  iClk     in   1              clock, all state on rising edge
//  iRst_n   in   1              asynchronous active-low reset
//  iValid   in   1              request valid
//  oReady   out  1              sequencer can accept a request this cycle
//  iA       in   OPERAND_WIDTH  operand A
//  iB       in   OPERAND_WIDTH  operand B
//  iC       in   1              carry-in (add) / borrow-in (sub)
//  iSub     in   1              1 = subtract, A - B - iC
//  oValid   out  1              result valid
//  iReady   in   1              consumer accepts result
//  oSum     out  OPERAND_WIDTH  result
//  oC       out  1              carry-out; for sub, 1 = no borrow
//  oBusy    out  1              high in RUN
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, oValid=0, oSum=0, oC=0, oBusy=0, chunk cnt=0, oReady=1.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: oReady=1. On iValid:
//    - latch A -> rA, (iSub ? ~iB : iB) -> rB.
//    - carry reg <= iC ^ iSub.
//    - cnt <= 0; -> RUN.
//   RUN: oReady=0, oBusy=1. Each cycle the slice adds rA/rB chunk[cnt] with carry reg.
//    - oSum chunk[cnt] <= slice sum; carry reg <= slice carry-out; cnt <= cnt+1.
//    - After chunk NUM_CHUNKS-1: oC <= final carry; -> DONE.
//   DONE: oValid=1; oSum/oC stable until handshake.
//    - iReady=1: oValid drops next cycle.
//    - iReady=0: hold indefinitely; no timeout.
//   DONE & iReady & iValid: oReady=1 (combinational from iReady). New request latched
//    same edge -> RUN, no IDLE bubble. DONE & iReady & !iValid -> IDLE.
//  Latency: request accepted at edge E -> oValid high after edge E+NUM_CHUNKS. Chunks fixed at
//   NUM_CHUNKS cycles; no early-out on carry-free operands.
//  Throughput: one result per NUM_CHUNKS+1 cycles with back-to-back handshake.
//  iA/iB/iC/iSub sampled only on the accept edge; changes during RUN/DONE are ignored.
//  iValid while RUN, or while DONE with iReady=0: not accepted; producer holds it (oReady=0).
//  oSum is partially written during RUN; only defined when oValid=1.
//  Arithmetic: oSum = (A + B' + cin) mod 2^OPERAND_WIDTH; {oC,oSum} = A + B' + cin
//   (B' = iSub ? ~iB : iB, cin = iC ^ iSub).
//  NUM_CHUNKS=1: RUN lasts exactly one cycle.
//  Reset mid-RUN/DONE: immediate return to IDLE, pending result discarded, oValid=0.
// TESTING  (OPERAND_WIDTH=32, ADDER_WIDTH=8 unless noted)
//  1. A=FFFFFFFF, B=00000001, iC=0, add
//     -> oValid 4 cycles after accept; oSum=00000000, oC=1 (full carry ripple).
//  2. A=00000000, B=00000001, iC=0, iSub=1 -> oSum=FFFFFFFF, oC=0 (borrow).
//     Then A=5, B=3, iC=1, iSub=1 -> oSum=00000001, oC=1.
//  3. Backpressure: iReady=0 for 10 cycles in DONE.
//     -> oValid held, oSum/oC stable, oReady=0, a new iValid not accepted.
//  4. Back-to-back: iValid held with iReady=1.
//     -> results every 5 cycles; sequence 12345678+87654321 (99999999, oC=0),
//        then 80000000+80000000 (00000000, oC=1).
//  5. Deassert iRst_n in 2nd RUN cycle -> oValid=0, oReady=1 at once.
//     Next request completes correctly, no stale carry.
//  6. Random (A,B,iC,iSub) vs 33-bit reference model, 10k vectors;
//     repeat with OPERAND_WIDTH=8 (1 chunk) and 128 -> zero mismatches.

Source files
------------

// File: rtl/mp_add_sequencer.sv
// Wide add/subtract sequencer: streams OPERAND_WIDTH-bit operands through one
// ADDER_WIDTH-bit carry-lookahead slice, LSB chunk first, with a registered inter-chunk carry.

module mp_add_cla_slice #(
   parameter int W = 8
) (
   input  logic [W-1:0] iA,
   input  logic [W-1:0] iB,
   input  logic         iC,
   output logic [W-1:0] oSum,
   output logic         oC
);

   logic [W-1:0] gen;
   logic [W-1:0] prop;
   logic [W:0]   carry;

   assign gen  = iA & iB;
   assign prop = iA ^ iB;

   // Each carry is a flat sum-of-products over generate/propagate terms,
   // so no carry depends on a lower carry.
   always_comb begin : carry_tree
      logic term_acc;
      logic prop_acc;
      // NOTE: every variable written here gets a default first, so no path can leave it holding state (no latch).
      carry    = '0;
      term_acc = 1'b0;
      prop_acc = 1'b0;
      carry[0] = iC;
      for (int i = 0; i < W; i++) begin
         term_acc = gen[i];
         prop_acc = prop[i];
         for (int j = i - 1; j >= 0; j--) begin
            term_acc = term_acc | (prop_acc & gen[j]);
            prop_acc = prop_acc & prop[j];
         end
         carry[i+1] = term_acc | (prop_acc & iC);
      end
   end

   assign oSum = prop ^ carry[W-1:0];
   assign oC   = carry[W];

endmodule

module mp_add_sequencer #(
   parameter int ADDER_WIDTH   = 8,
   parameter int OPERAND_WIDTH = 64
) (
   input  logic                     iClk,
   input  logic                     iRst_n,
   input  logic                     iValid,
   output logic                     oReady,
   input  logic [OPERAND_WIDTH-1:0] iA,
   input  logic [OPERAND_WIDTH-1:0] iB,
   input  logic                     iC,
   input  logic                     iSub,
   output logic                     oValid,
   input  logic                     iReady,
   output logic [OPERAND_WIDTH-1:0] oSum,
   output logic                     oC,
   output logic                     oBusy
);

   localparam int NUM_CHUNKS = OPERAND_WIDTH / ADDER_WIDTH;
   localparam int CNT_W      = $clog2(NUM_CHUNKS + 1);
   localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t                   state;
   state_t                   state_nxt;
   logic [OPERAND_WIDTH-1:0] ra;
   logic [OPERAND_WIDTH-1:0] rb;
   logic                     carry;
   logic [CNT_W-1:0]         cnt;
   logic                     accept;
   logic                     last_chunk;
   logic [ADDER_WIDTH-1:0]   chunk_a;
   logic [ADDER_WIDTH-1:0]   chunk_b;
   logic [ADDER_WIDTH-1:0]   slice_sum;
   logic                     slice_c;

   assign accept     = iValid & oReady;
   assign last_chunk = (cnt == LAST_CHUNK);
   assign chunk_a    = ra[int'(cnt)*ADDER_WIDTH +: ADDER_WIDTH];
   assign chunk_b    = rb[int'(cnt)*ADDER_WIDTH +: ADDER_WIDTH];

   mp_add_cla_slice #(
      .W (ADDER_WIDTH)
   ) u_slice (
      .iA   (chunk_a),
      .iB   (chunk_b),
      .iC   (carry),
      .oSum (slice_sum),
      .oC   (slice_c)
   );

   // A finished result can hand off straight into a new request when the consumer takes it.
   always_comb begin
      state_nxt = state;
      oReady    = 1'b0;
      oBusy     = 1'b0;
      oValid    = 1'b0;
      case (state)
         IDLE: begin
            oReady = 1'b1;
            if (iValid) state_nxt = RUN;
         end
         RUN: begin
            oBusy = 1'b1;
            if (last_chunk) state_nxt = DONE;
         end
         DONE: begin
            oValid = 1'b1;
            oReady = iReady;
            if (iReady) state_nxt = iValid ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) state <= IDLE;
      else         state <= state_nxt;
   end

   // Subtraction is A + ~B + 1; the borrow-in is folded into the inverted carry-in.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         ra    <= '0;
         rb    <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         oSum  <= '0;
         oC    <= 1'b0;
      end else if (accept) begin
         ra    <= iA;
         rb    <= iSub ? ~iB : iB;
         carry <= iC ^ iSub;
         cnt   <= '0;
      end else if (state == RUN) begin
         oSum[int'(cnt)*ADDER_WIDTH +: ADDER_WIDTH] <= slice_sum;
         carry <= slice_c;
         cnt   <= cnt + 1'b1;
         if (last_chunk) oC <= slice_c;
      end
   end

endmodule
